// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side pointer, empty flag and FWFT output stage
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AE_THRESH  = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic [AW:0]           sync_gray_wptr,
  input  logic [DATA_WIDTH-1:0] R_data_mem,
  input  logic                  rd_ready,
  output logic [AW-1:0]         R_addr,
  output logic [AW:0]           gray_rd_ptr,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [AW:0]           rd_level,
  output logic                  almost_empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AE_LVL  = (AW+1)'(AE_THRESH);

  typedef enum logic {IDLE, LOADED} state_t;

  state_t      state;
  logic [AW:0] bn_rd_ptr;
  logic [AW:0] bn_nxt;
  logic [AW:0] wb;
  logic [AW:0] level_nxt;
  logic        take;
  logic        fetch;

  assign R_addr = bn_rd_ptr[AW-1:0];
  assign empty  = (gray_rd_ptr == sync_gray_wptr);
  assign take   = rd_valid & rd_ready;
  assign fetch  = !empty & (!rd_valid | rd_ready);
  assign bn_nxt = bn_rd_ptr + PTR_ONE;

  // Binary view of the synchronized write pointer, used only for the level estimate.
  always_comb begin
    wb     = '0;
    wb[AW] = sync_gray_wptr[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      wb[i] = wb[i+1] ^ sync_gray_wptr[i];
    end
  end

  assign level_nxt = (wb - bn_rd_ptr) + {{AW{1'b0}}, rd_valid};

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      bn_rd_ptr   <= '0;
      gray_rd_ptr <= '0;
    end else if (fetch) begin
      bn_rd_ptr   <= bn_nxt;
      gray_rd_ptr <= bn_nxt ^ (bn_nxt >> 1);
    end
  end

  // Output-register handshake; a take and a fetch on the same edge keep LOADED.
  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch) begin
            state    <= LOADED;
            rd_valid <= 1'b1;
            rd_data  <= R_data_mem;
          end
        end
        LOADED: begin
          if (fetch) begin
            rd_data <= R_data_mem;
          end else if (take) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_nxt;
      almost_empty <= (level_nxt <= AE_LVL);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for the FIFO read-side controller
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          R_CLK = 1'b0;
  logic          R_RST = 1'b0;
  logic [AW:0]   sync_gray_wptr = '0;
  logic [DW-1:0] R_data_mem;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] R_addr;
  logic [AW:0]   gray_rd_ptr;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   rd_level;
  logic          almost_empty;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AE_THRESH(1)) dut (
    .R_CLK(R_CLK), .R_RST(R_RST), .sync_gray_wptr(sync_gray_wptr),
    .R_data_mem(R_data_mem), .rd_ready(rd_ready), .R_addr(R_addr),
    .gray_rd_ptr(gray_rd_ptr), .empty(empty), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_level(rd_level), .almost_empty(almost_empty)
  );

  always #5 R_CLK = ~R_CLK;

  logic [DW-1:0] mem [DEPTH];
  assign R_data_mem = mem[R_addr];

  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   wptr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge R_CLK);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    mem[wptr[AW-1:0]] = v;
    exp_q.push_back(v);
    wptr = wptr + 1'b1;
    sync_gray_wptr = wptr ^ (wptr >> 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (rd_valid && n < 50) begin
      tick;
      n++;
    end
    check(name, rd_valid, 0);
  endtask

  // Scoreboard monitor: every accepted word must match the next expected one.
  always @(negedge R_CLK) begin
    if (!R_RST && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_extra: got 0x%0h expected no word", rd_data);
      end else begin
        check("scoreboard_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] wrap_addr [4];
  logic [AW:0]   wrap_gray [4];

  initial begin
    wrap_addr = '{3'd7, 3'd0, 3'd1, 3'd2};
    wrap_gray = '{4'b1000, 4'b0000, 4'b0001, 4'b0011};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // reset asserted between edges
    #2 R_RST = 1'b1;
    #1;
    check("rst_addr", R_addr, 0);
    check("rst_gray", gray_rd_ptr, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_level", rd_level, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_empty", empty, 1);
    tick;
    tick;
    R_RST = 1'b0;
    tick;
    check("idle_empty", empty, 1);

    // single word with consumer stalled
    rd_ready = 1'b0;
    write_word(8'hA5);
    #1;
    check("single_empty_falls", empty, 0);
    tick;
    check("single_valid", rd_valid, 1);
    check("single_data", rd_data, 8'hA5);
    check("single_gray", gray_rd_ptr, 1);
    check("single_empty", empty, 1);
    check("single_addr", R_addr, 1);
    tick;
    check("single_level", rd_level, 1);
    check("single_ae", almost_empty, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("single_hold_data", rd_data, 8'hA5);
      check("single_hold_valid", rd_valid, 1);
    end
    rd_ready = 1'b1;
    tick;
    check("single_taken", rd_valid, 0);
    tick;
    check("single_level0", rd_level, 0);

    // backpressure: 8 words arrive while consumer is stalled
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_word(8'h10 + 8'(i));
      tick;
    end
    tick;
    tick;
    check("bp_one_fetch_addr", R_addr, 2);
    check("bp_level", rd_level, 8);
    check("bp_ae", almost_empty, 0);
    check("bp_head", rd_data, 8'h10);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_no_gap", rd_valid, 1);
      tick;
    end
    check("drain_valid", rd_valid, 0);
    check("drain_empty", empty, 1);
    check("drain_addr", R_addr, 1);
    tick;
    check("drain_ae", almost_empty, 1);
    check("drain_level", rd_level, 0);

    // advance read pointer to 14, then stream across the wrap
    for (int i = 0; i < 5; i++) begin
      write_word(8'h20 + 8'(i));
      tick;
    end
    wait_idle("pre_wrap_idle");
    check("pre_wrap_addr", R_addr, 6);
    check("pre_wrap_gray", gray_rd_ptr, 4'b1001);
    for (int i = 0; i < 4; i++) write_word(8'h30 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      tick;
      check("wrap_addr", R_addr, wrap_addr[k]);
      check("wrap_gray", gray_rd_ptr, wrap_gray[k]);
      check("wrap_valid", rd_valid, 1);
    end
    tick;
    check("wrap_done", rd_valid, 0);

    // reset mid-stream with a word held and pointer at 5
    for (int i = 0; i < 3; i++) write_word(8'h40 + 8'(i));
    tick;
    tick;
    tick;
    rd_ready = 1'b0;
    check("mid_addr", R_addr, 5);
    check("mid_valid", rd_valid, 1);
    check("mid_data", rd_data, 8'h42);
    #1 R_RST = 1'b1;
    exp_q.delete();
    wptr = '0;
    sync_gray_wptr = '0;
    #1;
    check("mid_rst_addr", R_addr, 0);
    check("mid_rst_gray", gray_rd_ptr, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_empty", empty, 1);
    tick;
    R_RST = 1'b0;
    tick;
    write_word(8'h5A);
    tick;
    check("resume_valid", rd_valid, 1);
    check("resume_data", rd_data, 8'h5A);
    check("resume_addr", R_addr, 1);
    rd_ready = 1'b1;
    tick;
    check("resume_taken", rd_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
